dsm_multi: RTL

- Parametrised multi-channel delta-sigma DAC modulator; successor to the fixed stereo first-order modulator.
- Takes NUM_CH offset-binary PCM words per frame via a valid/ready handshake and double-buffers them.
- Runs a first- or second-order loop per channel on every clk, emitting one 1-bit stream per channel to the output pins or filter.

---
 rtl/dsm_multi.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/dsm_multi.sv
// Multi-channel first/second-order delta-sigma DAC modulator.
// Double-buffered PCM input, frame-synchronous mode/mute/sample update.
module dsm_multi #(
    parameter int DSM_WIDTH = 12,
    parameter int NUM_CH    = 2,
    parameter int OSR       = 64
) (
    input  logic                        clk,
    input  logic                        aclr,
    input  logic                        mode,
    input  logic                        mute,
    input  logic [NUM_CH*DSM_WIDTH-1:0] pcm_in,
    input  logic                        pcm_valid,
    output logic                        pcm_ready,
    output logic                        frame_tick,
    output logic                        underrun,
    output logic [NUM_CH-1:0]           dsm_out
);
    localparam int W  = DSM_WIDTH;
    localparam int IW = W + 4;
    localparam int SW = W + 6;
    localparam int CW = $clog2(OSR);
    localparam logic [W-1:0]         MID  = W'(2 ** (W - 1));
    localparam logic signed [SW-1:0] HALF = SW'(2 ** (W - 1));
    localparam logic signed [SW-1:0] SATP = SW'(2 ** (W + 2) - 1);
    localparam logic signed [SW-1:0] SATN = -SATP;
    localparam logic [CW-1:0]        LAST = CW'(OSR - 1);

    logic [CW-1:0]       cnt_q, cnt_d;
    logic [NUM_CH*W-1:0] pend_q, pend_d;
    logic [NUM_CH*W-1:0] act_q, act_d;
    logic                full_q, full_d;
    logic                mode_q, mode_d;
    logic                mute_q, mute_d;
    logic                tick_q, tick_d;
    logic                under_q, under_d;
    logic                frame_end;
    logic                mode_chg;

    function automatic logic signed [IW-1:0] sat(input logic signed [SW-1:0] v);
        if (v > SATP)
            return SATP[IW-1:0];
        else if (v < SATN)
            return SATN[IW-1:0];
        else
            return v[IW-1:0];
    endfunction

    always_comb begin
        frame_end = (cnt_q == LAST);
        mode_chg  = frame_end & (mode != mode_q);
        cnt_d     = frame_end ? '0 : cnt_q + CW'(1);
        tick_d    = frame_end;
        pend_d    = pend_q;
        full_d    = full_q;
        act_d     = act_q;
        mode_d    = mode_q;
        mute_d    = mute_q;
        under_d   = under_q;
        if (pcm_valid && !full_q) begin
            pend_d = pcm_in;
            full_d = 1'b1;
        end
        // A transfer landing on an empty boundary stays pending for the next frame
        if (frame_end) begin
            mode_d = mode;
            mute_d = mute;
            if (full_q) begin
                act_d  = pend_q;
                full_d = 1'b0;
            end else begin
                under_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (aclr) begin
            cnt_q   <= '0;
            pend_q  <= '0;
            full_q  <= 1'b0;
            act_q   <= {NUM_CH{MID}};
            mode_q  <= 1'b0;
            mute_q  <= 1'b0;
            tick_q  <= 1'b0;
            under_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            full_q  <= full_d;
            act_q   <= act_d;
            mode_q  <= mode_d;
            mute_q  <= mute_d;
            tick_q  <= tick_d;
            under_q <= under_d;
        end
    end

    assign pcm_ready  = ~full_q;
    assign frame_tick = tick_q;
    assign underrun   = under_q;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic [W:0]            acc_q, acc_d;
        logic signed [IW-1:0]  i1_q, i1_d, i2_q, i2_d;
        logic signed [IW-1:0]  i1n, i2n;
        logic                  y_q, y_d;
        logic [W-1:0]          x;
        logic signed [SW-1:0]  xc, fb;

        always_comb begin
            x     = mute_q ? MID : act_q[k*W +: W];
            xc    = $signed({{(SW-W){1'b0}}, x}) - HALF;
            fb    = y_q ? HALF : -HALF;
            i1n   = sat(SW'(i1_q) + xc - fb);
            i2n   = sat(SW'(i2_q) + SW'(i1_q) - fb);
            acc_d = acc_q;
            i1_d  = i1_q;
            i2_d  = i2_q;
            y_d   = y_q;
            if (mode_chg) begin
                acc_d = '0;
                i1_d  = '0;
                i2_d  = '0;
                y_d   = 1'b0;
            end else if (mode_q) begin
                i1_d = i1n;
                i2_d = i2n;
                y_d  = ~i2n[IW-1];
            end else begin
                acc_d = {1'b0, acc_q[W-1:0]} + {1'b0, x};
            end
        end

        always_ff @(posedge clk) begin
            if (aclr) begin
                acc_q <= '0;
                i1_q  <= '0;
                i2_q  <= '0;
                y_q   <= 1'b0;
            end else begin
                acc_q <= acc_d;
                i1_q  <= i1_d;
                i2_q  <= i2_d;
                y_q   <= y_d;
            end
        end

        assign dsm_out[k] = mode_q ? y_q : acc_q[W];
    end

endmodule
